// File: rtl/adc_conv_sequencer.sv
// ADC macro sequencer: conversion control, timed calibration window and a
// first-word-fall-through sample buffer between the macro and the CPU-side registers.
//
// state     | meaning
// S_IDLE    | waiting for start_i or calib_req_i
// S_CALIB   | calib_en_o held high for CALIB_CYCLES cycles
// S_CONVERT | adc_en_o high, waiting for EOC or timeout
module adc_conv_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CALIB_CYCLES   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          cont_i,
  input  logic                          calib_req_i,
  input  logic                          abort_i,
  input  logic                          clr_flags_i,
  output logic                          adc_en_o,
  output logic                          calib_en_o,
  input  logic                          adc_eoc_n_i,
  input  logic [DATA_WIDTH-1:0]         adc_data_i,
  output logic                          sample_valid_o,
  output logic [DATA_WIDTH-1:0]         sample_data_o,
  input  logic                          sample_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o,
  output logic                          calib_done_o,
  output logic                          timeout_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int KW = $clog2(CALIB_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] CALIB_LOAD   = KW'(CALIB_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CALIB   = 2'd1,
    S_CONVERT = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            mode, mode_next;
  logic [TW-1:0]   timer, timer_next;
  logic [KW-1:0]   calib_cnt, calib_cnt_next;
  logic            done_next;
  logic            timeout_set;
  logic            eoc;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]   wr_ptr, rd_ptr, count;
  logic            fifo_empty, fifo_full, push_ok, pop, overflow_set;

  assign eoc = (state == S_CONVERT) && !adc_eoc_n_i;

  always_comb begin
    state_next     = state;
    mode_next      = mode;
    timer_next     = timer;
    calib_cnt_next = calib_cnt;
    done_next      = 1'b0;
    timeout_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (calib_req_i) begin
          state_next     = S_CALIB;
          calib_cnt_next = CALIB_LOAD;
        end else if (start_i) begin
          state_next = S_CONVERT;
          mode_next  = cont_i;
          timer_next = TIMEOUT_LOAD;
        end
      end
      S_CALIB: begin
        if (calib_cnt == '0) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          calib_cnt_next = calib_cnt - 1'b1;
        end
      end
      S_CONVERT: begin
        // EOC on the terminal cycle still counts as a good conversion
        if (eoc) begin
          timer_next = TIMEOUT_LOAD;
          if (!mode) state_next = S_IDLE;
        end else if (timer == '0) begin
          state_next  = S_IDLE;
          timeout_set = 1'b1;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (abort_i) begin
      state_next  = S_IDLE;
      done_next   = 1'b0;
      timeout_set = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mode         <= 1'b0;
      timer        <= '0;
      calib_cnt    <= '0;
      adc_en_o     <= 1'b0;
      calib_en_o   <= 1'b0;
      calib_done_o <= 1'b0;
    end else begin
      state        <= state_next;
      mode         <= mode_next;
      timer        <= timer_next;
      calib_cnt    <= calib_cnt_next;
      adc_en_o     <= (state_next == S_CONVERT);
      calib_en_o   <= (state_next == S_CALIB);
      calib_done_o <= done_next;
    end
  end

  assign busy_o = (state != S_IDLE);

  assign count        = wr_ptr - rd_ptr;
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_COUNT);
  assign pop          = sample_ready_i && !fifo_empty;
  assign push_ok      = eoc && (!fifo_full || pop);
  assign overflow_set = eoc && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      timeout_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      timeout_o  <= timeout_set  ? 1'b1 : (clr_flags_i ? 1'b0 : timeout_o);
      overflow_o <= overflow_set ? 1'b1 : (clr_flags_i ? 1'b0 : overflow_o);
    end
  end

  // storage needs no reset; the head is masked while the buffer is empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= adc_data_i;
  end

  assign sample_valid_o = !fifo_empty;
  assign sample_data_o  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign fifo_count_o   = count;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer: expected samples go into a queue, a
// negedge monitor checks every popped sample; control outputs checked inline.
module tb_adc_conv_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_i = 0, cont_i = 0, calib_req_i = 0, abort_i = 0, clr_flags_i = 0;
  logic       adc_eoc_n_i = 1'b1;
  logic [7:0] adc_data_i = '0;
  logic       sample_ready_i = 1'b0;
  logic       adc_en_o, calib_en_o, sample_valid_o, busy_o, calib_done_o, timeout_o, overflow_o;
  logic [7:0] sample_data_o;
  logic [2:0] fifo_count_o;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  adc_conv_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i), .calib_req_i(calib_req_i),
    .abort_i(abort_i), .clr_flags_i(clr_flags_i), .adc_en_o(adc_en_o), .calib_en_o(calib_en_o),
    .adc_eoc_n_i(adc_eoc_n_i), .adc_data_i(adc_data_i), .sample_valid_o(sample_valid_o),
    .sample_data_o(sample_data_o), .sample_ready_i(sample_ready_i), .fifo_count_o(fifo_count_o),
    .busy_o(busy_o), .calib_done_o(calib_done_o), .timeout_o(timeout_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic eoc(input logic [7:0] d, input bit expect_kept);
    adc_eoc_n_i = 1'b0;
    adc_data_i  = d;
    if (expect_kept) exp_q.push_back(d);
    cyc();
    adc_eoc_n_i = 1'b1;
    adc_data_i  = '0;
  endtask

  task automatic drain(input int n);
    sample_ready_i = 1'b1;
    cycn(n);
    sample_ready_i = 1'b0;
  endtask

  // scoreboard monitor: every accepted pop must match the oldest expected sample
  always @(negedge clk) begin
    if (!rst && sample_valid_o && sample_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_pop", {24'd0, sample_data_o}, 32'hFFFF_FFFF);
      else chk("sample_data", {24'd0, sample_data_o}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    #12;
    chk("rst_adc_en", adc_en_o, 0);
    chk("rst_valid", sample_valid_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 1'b0;
    cyc();

    // single-shot conversion
    start_i = 1; cont_i = 0; cyc(); start_i = 0;
    chk("ss_adc_en_on", adc_en_o, 1);
    chk("ss_busy_on", busy_o, 1);
    cycn(9);
    eoc(8'h55, 1);
    chk("ss_valid", sample_valid_o, 1);
    chk("ss_head", sample_data_o, 8'h55);
    chk("ss_adc_en_off", adc_en_o, 0);
    chk("ss_busy_off", busy_o, 0);
    chk("ss_count", fifo_count_o, 1);
    drain(1);
    chk("ss_count_drained", fifo_count_o, 0);

    // continuous mode overflow; last EOC coincides with clr_flags_i (set wins)
    start_i = 1; cont_i = 1; cyc(); start_i = 0; cont_i = 0;
    for (int i = 1; i <= 4; i++) begin
      eoc(8'(i), 1);
      cyc();
    end
    chk("ov_no_flag_yet", overflow_o, 0);
    clr_flags_i = 1;
    eoc(8'h05, 0);
    clr_flags_i = 0;
    chk("ov_count", fifo_count_o, 4);
    chk("ov_flag", overflow_o, 1);
    chk("ov_still_busy", busy_o, 1);
    abort_i = 1; cyc(); abort_i = 0;
    chk("ov_abort_idle", busy_o, 0);
    chk("ov_abort_keeps", fifo_count_o, 4);
    drain(4);
    chk("ov_drained", fifo_count_o, 0);
    clr_flags_i = 1; cyc(); clr_flags_i = 0;
    chk("ov_cleared", overflow_o, 0);

    // full FIFO with simultaneous push and pop
    start_i = 1; cont_i = 1; cyc(); start_i = 0; cont_i = 0;
    for (int i = 0; i < 4; i++) begin
      eoc(8'h10 + 8'(i), 1);
    end
    chk("fp_full", fifo_count_o, 4);
    sample_ready_i = 1;
    eoc(8'hAA, 1);
    sample_ready_i = 0;
    chk("fp_count", fifo_count_o, 4);
    chk("fp_no_ov", overflow_o, 0);
    abort_i = 1; cyc(); abort_i = 0;
    drain(4);
    chk("fp_drained", fifo_count_o, 0);

    // timeout window length
    start_i = 1; cyc(); start_i = 0;
    n = 0;
    while (adc_en_o && n < 1100) begin
      n++;
      cyc();
    end
    chk("to_en_cycles", n, 1024);
    chk("to_flag", timeout_o, 1);
    chk("to_busy", busy_o, 0);
    clr_flags_i = 1; cyc(); clr_flags_i = 0;
    chk("to_cleared", timeout_o, 0);

    // EOC on the terminal timer cycle wins over timeout
    start_i = 1; cyc(); start_i = 0;
    cycn(1023);
    chk("tb_still_conv", adc_en_o, 1);
    eoc(8'h77, 1);
    chk("tb_no_timeout", timeout_o, 0);
    chk("tb_idle", busy_o, 0);
    chk("tb_count", fifo_count_o, 1);
    drain(1);

    // calibration has priority over a coincident start
    calib_req_i = 1; start_i = 1; cyc(); calib_req_i = 0; start_i = 0;
    n = 0;
    while (calib_en_o && n < 40) begin
      if (adc_en_o) chk("cal_no_conv", adc_en_o, 0);
      n++;
      cyc();
    end
    chk("cal_cycles", n, 16);
    chk("cal_done_pulse", calib_done_o, 1);
    chk("cal_adc_en", adc_en_o, 0);
    cyc();
    chk("cal_done_one_cycle", calib_done_o, 0);
    chk("cal_idle", busy_o, 0);

    // abort during calibration: no done pulse
    calib_req_i = 1; cyc(); calib_req_i = 0;
    cycn(5);
    abort_i = 1; cyc(); abort_i = 0;
    chk("cab_calib_off", calib_en_o, 0);
    chk("cab_no_done", calib_done_o, 0);

    // abort then reset mid-CONVERT
    start_i = 1; cont_i = 1; cyc(); start_i = 0; cont_i = 0;
    eoc(8'h21, 1);
    eoc(8'h22, 1);
    abort_i = 1; cyc(); abort_i = 0;
    chk("ab_idle", busy_o, 0);
    chk("ab_kept", fifo_count_o, 2);
    start_i = 1; cyc(); start_i = 0;
    cycn(3);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rs_adc_en", adc_en_o, 0);
    chk("rs_busy", busy_o, 0);
    chk("rs_count", fifo_count_o, 0);
    chk("rs_valid", sample_valid_o, 0);
    chk("rs_data", sample_data_o, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("rs_after_count", fifo_count_o, 0);

    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
